// File: rtl/riscv_definitions.sv
// +------------------------------------------------------------------+
// | riscv_definitions: shared funct3 encodings, bus and state types  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package riscv_definitions;

  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } funct3ITypeLOAD_e;

  typedef enum logic [2:0] {
    F3_SB = 3'd0,
    F3_SH = 3'd1,
    F3_SW = 3'd2
  } funct3SType_e;

  typedef union packed {
    logic [31:0]      word;
    logic [1:0][15:0] half;
    logic [3:0][7:0]  bytes;
  } dataBus_u;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmemState_e;

  // Byte accesses are always aligned; reserved encodings are rejected elsewhere.
  function automatic logic isAligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      3'd1, 3'd5: return ~addr_lo[0];
      3'd2:       return (addr_lo == 2'b00);
      default:    return 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_lsu_align.sv
// +------------------------------------------------------------------+
// | riscv_lsu_align: load extract/extend, store lane merge, checks   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module riscv_lsu_align
  import riscv_definitions::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic [3:0]  store_be,
  output logic [31:0] store_data,
  output logic        misaligned,
  output logic        reserved
);

  dataBus_u    rd;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign rd       = mem_rdata;
  assign sel_byte = rd.bytes[addr_lo];
  assign sel_half = rd.half[addr_lo[1]];

  always_comb begin
    load_data = 32'd0;
    case (funct3ITypeLOAD_e'(funct3))
      F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      F3_LW:   load_data = rd.word;
      F3_LBU:  load_data = {24'd0, sel_byte};
      F3_LHU:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    store_be   = 4'b0000;
    store_data = 32'd0;
    case (funct3SType_e'(funct3))
      F3_SB: begin
        store_be   = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      F3_SH: begin
        store_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      F3_SW: begin
        store_be   = 4'b1111;
        store_data = wdata;
      end
      default: begin
        store_be   = 4'b0000;
        store_data = 32'd0;
      end
    endcase
  end

  assign misaligned = ~isAligned(funct3, addr_lo);
  assign reserved   = we ? (funct3 > 3'd2) : ((funct3 == 3'd3) || (funct3 >= 3'd6));

endmodule

`default_nettype wire

// File: rtl/riscv_data_mem.sv
// +------------------------------------------------------------------+
// | riscv_data_mem: single-port data memory responder, wait states   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module riscv_data_mem
  import riscv_definitions::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmemState_e state, state_next;
  logic [3:0] wait_cnt, wait_cnt_next;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic                  accept, access, from_req;
  logic                  acc_we;
  logic [31:0]           acc_addr, acc_wdata;
  logic [2:0]            acc_funct3;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           mem_rdata, load_data, store_data;
  logic [3:0]            store_be;
  logic                  misaligned, reserved, out_of_range, err, mem_wr;

  assign req_ready = (state == DMEM_IDLE);
  assign rsp_valid = (state == DMEM_RESP);
  assign accept    = req_ready & req_valid;
  assign access    = (accept && (WAIT_STATES == 0)) || ((state == DMEM_WAIT) && (wait_cnt == 4'd0));

  // With no wait states the access happens on the accepting edge, before the latch holds it.
  assign from_req   = (state == DMEM_IDLE);
  assign acc_we     = from_req ? req_we     : lat_we;
  assign acc_addr   = from_req ? req_addr   : lat_addr;
  assign acc_funct3 = from_req ? req_funct3 : lat_funct3;
  assign acc_wdata  = from_req ? req_wdata  : lat_wdata;

  assign word_idx     = acc_addr[ADDR_WIDTH+1:2];
  assign mem_rdata    = mem[word_idx];
  assign out_of_range = (acc_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign err          = misaligned | reserved | out_of_range;
  assign mem_wr       = access & acc_we & ~err & rst_n;

  riscv_lsu_align u_align (
    .funct3     (acc_funct3),
    .we         (acc_we),
    .addr_lo    (acc_addr[1:0]),
    .wdata      (acc_wdata),
    .mem_rdata  (mem_rdata),
    .load_data  (load_data),
    .store_be   (store_be),
    .store_data (store_data),
    .misaligned (misaligned),
    .reserved   (reserved)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DMEM_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      DMEM_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_next    = DMEM_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = DMEM_RESP;
          end
        end
      end
      DMEM_WAIT: begin
        if (wait_cnt == 4'd0) state_next = DMEM_RESP;
        else                  wait_cnt_next = wait_cnt - 4'd1;
      end
      DMEM_RESP: begin
        if (rsp_ready) state_next = DMEM_IDLE;
      end
      default: state_next = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_funct3 <= 3'd0;
      lat_wdata  <= 32'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_funct3 <= req_funct3;
        lat_wdata  <= req_wdata;
      end
      if (access) begin
        rsp_rdata <= (err || acc_we) ? 32'd0 : load_data;
        rsp_err   <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem: vector table on a 1-wait-state instance,
// plus sequences for backpressure, wait-state sweep and mid-operation reset.
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_data_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [2:0]  req_funct3[3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_data_mem #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  riscv_data_mem #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  riscv_data_mem #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_ws3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_funct3(req_funct3[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd, input logic rr);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_funct3[d] = f3;
    req_wdata[d]  = wd;
    rsp_ready[d]  = rr;
  endtask

  // Returns after the accepting edge with rsp_valid seen (or budget spent); lat counts
  // edges from the accepting edge inclusive to the one that raised rsp_valid.
  task automatic wait_rsp(input int d, output int lat);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid[d]) chk("rsp_timeout", 32'(lat), 32'd0);
  endtask

  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [2:0] f3,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    drive(d, we, addr, f3, wd, 1'b1);
    wait_rsp(d, lat);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 0; req_we[i] = 0; req_addr[i] = 0;
      req_funct3[i] = 0; req_wdata[i] = 0; rsp_ready[i] = 1;
    end

    vecs.push_back('{1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h13,   3'd0, 32'h0,        32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, 32'h13,   3'd4, 32'h0,        32'h000000DE, 1'b0});
    vecs.push_back('{1'b0, 32'h12,   3'd1, 32'h0,        32'hFFFFDEAD, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd5, 32'h0,        32'h0000BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'h11,   3'd0, 32'h000000AA, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h12,   3'd1, 32'h00001234, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'h1234AAEF, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd0, 32'h0,        32'hFFFFFFEF, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd1, 32'h0,        32'hFFFFAAEF, 1'b0});
    vecs.push_back('{1'b0, 32'h11,   3'd4, 32'h0,        32'h000000AA, 1'b0});
    vecs.push_back('{1'b0, 32'h12,   3'd2, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h11,   3'd1, 32'h00005678, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'h1234AAEF, 1'b0});
    vecs.push_back('{1'b0, 32'h10,   3'd3, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd6, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h1000, 3'd2, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h1000, 3'd2, 32'h11111111, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h10,   3'd3, 32'h22222222, 32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h10,   3'd7, 32'h33333333, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,   3'd2, 32'h0,        32'h1234AAEF, 1'b0});
    vecs.push_back('{1'b1, 32'h20,   3'd2, 32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h20,   3'd2, 32'h0,        32'h11223344, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("reset_rsp_err",   32'(rsp_err[0]), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Backpressure: response held, a competing store must not be accepted.
    drive(0, 1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
    wait_rsp(0, lat);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 32'h10, 3'd2, 32'h0, 1'b0);
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata[0], 32'h1234AAEF);
      chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_release_ready", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, er, lat);
    chk("bp_not_written", rd, 32'h1234AAEF);

    // Wait-state sweep.
    txn(1, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D, rd, er, lat);
    chk("ws0_store_lat", 32'(lat), 32'd1);
    txn(1, 1'b0, 32'h42, 3'd5, 32'h0, rd, er, lat);
    chk("ws0_load_rdata", rd, 32'h0000CAFE);
    chk("ws0_load_lat", 32'(lat), 32'd1);
    txn(2, 1'b1, 32'h40, 3'd2, 32'h89ABCDEF, rd, er, lat);
    chk("ws3_store_lat", 32'(lat), 32'd4);
    txn(2, 1'b0, 32'h41, 3'd0, 32'h0, rd, er, lat);
    chk("ws3_load_rdata", rd, 32'hFFFFFFCD);
    chk("ws3_load_lat", 32'(lat), 32'd4);

    // Reset during WAIT of a store: request dropped, nothing written.
    txn(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, er, lat);
    chk("pre_reset_rdata", rd, 32'h11223344);
    drive(0, 1'b1, 32'h20, 3'd2, 32'h00000055, 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("midwait_state", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midwait_req_ready", 32'(req_ready[0]), 32'd1);
    chk("midwait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midwait_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("midwait_rsp_err",   32'(rsp_err[0]), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    txn(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, er, lat);
    chk("midwait_no_write", rd, 32'h11223344);

    // Reset during RESP of a store: response cleared at once, write persists.
    drive(0, 1'b1, 32'h24, 3'd2, 32'hA5A5_5A5A, 1'b0);
    wait_rsp(0, lat);
    rst_n = 1'b0;
    #1;
    chk("midresp_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midresp_req_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;
    txn(0, 1'b0, 32'h24, 3'd2, 32'h0, rd, er, lat);
    chk("midresp_write_kept", rd, 32'hA5A55A5A);

    // Reset during RESP of a load: rdata returns to zero.
    drive(0, 1'b0, 32'h24, 3'd2, 32'h0, 1'b0);
    wait_rsp(0, lat);
    chk("resp_load_rdata", rsp_rdata[0], 32'hA5A55A5A);
    rst_n = 1'b0;
    #1;
    chk("midresp_load_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midresp_load_rdata", rsp_rdata[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready[0] = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
